// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a single-port memory.
// Each request is held until its ready strobe. A per-transaction watchdog
// ends a hung access with an error response.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   rN_req_i/rnw_i         requester N request and read(1)/write(0) select
//   rN_addr_i/wdata_i      requester N word address and write data
//   rN_ready_o             requester N one-cycle completion strobe
//   rN_rdata_o/err_o       read data / timeout flag, valid with rN_ready_o
//   mem_req_o/rnw_o        memory request and read/write select
//   mem_addr_o/wdata_o     memory address and write data
//   mem_ready_i/rdata_i    memory completion and read data
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req_i,
  input  logic              r0_rnw_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_wdata_i,
  output logic              r0_ready_o,
  output logic [DATA_W-1:0] r0_rdata_o,
  output logic              r0_err_o,
  input  logic              r1_req_i,
  input  logic              r1_rnw_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_wdata_i,
  output logic              r1_ready_o,
  output logic [DATA_W-1:0] r1_rdata_o,
  output logic              r1_err_o,
  output logic              mem_req_o,
  output logic              mem_rnw_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned     CntW   = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic busy;
  logic gnt_req;
  logic tmo;
  logic done;
  logic expire;
  logic resp;

  // Datapath and response steering.
  always_comb begin
    busy    = (state_q == StBusy);
    gnt_req = gnt_q ? r1_req_i : r0_req_i;
    tmo     = (cnt_q == CntMax) & ~mem_ready_i;
    // A requester dropping its request pulls mem_req_o down in the same cycle.
    mem_req_o = busy & gnt_req & ~tmo;
    done      = mem_req_o & mem_ready_i;
    expire    = busy & tmo & gnt_req;
    resp      = done | expire;

    mem_rnw_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (busy) begin
      mem_rnw_o   = gnt_q ? r1_rnw_i   : r0_rnw_i;
      mem_addr_o  = gnt_q ? r1_addr_i  : r0_addr_i;
      mem_wdata_o = gnt_q ? r1_wdata_i : r0_wdata_i;
    end

    r0_ready_o = 1'b0;
    r0_rdata_o = '0;
    r0_err_o   = 1'b0;
    r1_ready_o = 1'b0;
    r1_rdata_o = '0;
    r1_err_o   = 1'b0;
    if (resp) begin
      if (gnt_q) begin
        r1_ready_o = 1'b1;
        r1_rdata_o = done ? mem_rdata_i : '0;
        r1_err_o   = expire;
      end else begin
        r0_ready_o = 1'b1;
        r0_rdata_o = done ? mem_rdata_i : '0;
        r0_err_o   = expire;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (r0_req_i | r1_req_i) begin
          // On contention the requester not served last wins.
          gnt_d   = (r0_req_i & r1_req_i) ? ~last_q : r1_req_i;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!gnt_req) begin
          // Abandoned access: no response, fairness history untouched.
          state_d = StIdle;
        end else if (resp) begin
          last_d  = gnt_q;
          state_d = StIdle;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req_i, r0_rnw_i, r1_req_i, r1_rnw_i;
  logic [9:0]  r0_addr_i, r1_addr_i;
  logic [31:0] r0_wdata_i, r1_wdata_i;
  logic        r0_ready_o, r0_err_o, r1_ready_o, r1_err_o;
  logic [31:0] r0_rdata_o, r1_rdata_o;
  logic        mem_req_o, mem_rnw_o, mem_ready_i;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;

  mem_arbiter #(
    .ADDR_W (10),
    .DATA_W (32),
    .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .r0_req_i   (r0_req_i),
    .r0_rnw_i   (r0_rnw_i),
    .r0_addr_i  (r0_addr_i),
    .r0_wdata_i (r0_wdata_i),
    .r0_ready_o (r0_ready_o),
    .r0_rdata_o (r0_rdata_o),
    .r0_err_o   (r0_err_o),
    .r1_req_i   (r1_req_i),
    .r1_rnw_i   (r1_rnw_i),
    .r1_addr_i  (r1_addr_i),
    .r1_wdata_i (r1_wdata_i),
    .r1_ready_o (r1_ready_o),
    .r1_rdata_o (r1_rdata_o),
    .r1_err_o   (r1_err_o),
    .mem_req_o  (mem_req_o),
    .mem_rnw_o  (mem_rnw_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t exp0[$];
  resp_t exp1[$];
  int    gq[$];
  int    checks = 0;
  int    errors = 0;

  // Memory model: ready after lat request cycles; write responses return 0.
  logic [31:0] mem[1024];
  int          age = 0;
  int          lat = 1;
  assign mem_rdata_i = mem_rnw_o ? mem[mem_addr_o] : 32'h0;

  always @(negedge clk) begin
    if (reset) age = 0;
    else if (mem_req_o && mem_ready_i) begin
      if (!mem_rnw_o) mem[mem_addr_o] = mem_wdata_o;
      age = 0;
    end else if (mem_req_o) age++;
    else age = 0;
  end

  always @(posedge clk) begin
    #1;
    mem_ready_i = (age == lat);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int who, input logic [31:0] rd, input logic err);
    resp_t r;
    r.rdata = rd;
    r.err   = err;
    if (who == 0) exp0.push_back(r);
    else exp1.push_back(r);
    gq.push_back(who);
  endtask

  // Monitor state.
  int run = 0;
  int gap = 0;
  int ready_run = 0;
  bit prev_req = 0;
  bit seen = 0;
  bit gap_en = 0;

  task automatic check_resp(input int who);
    resp_t       r;
    logic [31:0] rd;
    logic        e;
    rd = (who == 0) ? r0_rdata_o : r1_rdata_o;
    e  = (who == 0) ? r0_err_o : r1_err_o;
    if ((who == 0 && exp0.size() == 0) || (who == 1 && exp1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ready r%0d: got ready with rdata %h err %0d, expected none",
               who, rd, e);
    end else begin
      r = (who == 0) ? exp0.pop_front() : exp1.pop_front();
      chk($sformatf("rdata_r%0d", who), rd, r.rdata);
      chk($sformatf("err_r%0d", who), 32'(e), 32'(r.err));
      if (gq.size() > 0) chk("grant_order", who, gq.pop_front());
      if (e) begin
        chk("tmo_mem_req", 32'(mem_req_o), 32'h0);
        chk("tmo_cycle", run, TMO);
      end else begin
        chk("done_mem_req", 32'(mem_req_o), 32'h1);
      end
    end
    ready_run = run;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      run = 0;
      gap = 0;
      prev_req = 0;
      seen = 0;
    end else begin
      chk("one_ready", 32'(r0_ready_o & r1_ready_o), 32'h0);
      if (r0_ready_o) check_resp(0);
      else chk("r0_quiet", r0_rdata_o | 32'(r0_err_o), 32'h0);
      if (r1_ready_o) check_resp(1);
      else chk("r1_quiet", r1_rdata_o | 32'(r1_err_o), 32'h0);
      if (!gap_en) seen = 0;
      if (mem_req_o && !prev_req) begin
        if (gap_en && seen) chk("idle_gap", gap, 1);
        seen = 1;
      end
      gap = mem_req_o ? 0 : gap + 1;
      prev_req = mem_req_o;
      run = mem_req_o ? run + 1 : 0;
    end
  end

  task automatic drive(input int who, input logic req, input logic rnw, input logic [9:0] addr,
                       input logic [31:0] wd);
    if (who == 0) begin
      r0_req_i = req; r0_rnw_i = rnw; r0_addr_i = addr; r0_wdata_i = wd;
    end else begin
      r1_req_i = req; r1_rnw_i = rnw; r1_addr_i = addr; r1_wdata_i = wd;
    end
  endtask

  // One transaction: raise, hold until ready (or reset), drop the cycle after ready.
  task automatic do_req(input int who, input logic rnw, input logic [9:0] addr,
                        input logic [31:0] wd, input bit chk_lat);
    bit got = 0;
    bit aborted = 0;
    @(posedge clk);
    #1;
    drive(who, 1'b1, rnw, addr, wd);
    if (chk_lat) begin
      @(negedge clk);
      chk("lat_idle_req", 32'(mem_req_o), 32'h0);
      @(negedge clk);
      chk("lat_busy_req", 32'(mem_req_o), 32'h1);
      chk("mem_addr", 32'(mem_addr_o), 32'(addr));
      chk("mem_rnw", 32'(mem_rnw_o), 32'(rnw));
      chk("mem_wdata", mem_wdata_o, wd);
    end
    for (int i = 0; i < 60 && !got && !aborted; i++) begin
      @(negedge clk);
      if (reset) aborted = 1;
      else if ((who == 0) ? r0_ready_o : r1_ready_o) got = 1;
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else if (!aborted) begin
      checks++;
      errors++;
      $display("FAIL req_wait r%0d: got no ready in 60 cycles, expected a ready", who);
    end
    drive(who, 1'b0, 1'b0, 10'h0, 32'h0);
  endtask

  logic [9:0]  a0[5], a1[5];
  logic [31:0] d0[5], d1[5];

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    mem_ready_i = 1'b0;
    drive(0, 1'b0, 1'b0, 10'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 10'h0, 32'h0);
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    #1;
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_r0_ready", 32'(r0_ready_o), 32'h0);
    chk("rst_r1_ready", 32'(r1_ready_o), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr_o), 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Single write then readback by r0.
    lat = 1;
    push_exp(0, 32'h0, 1'b0);
    do_req(0, 1'b0, 10'h05A, 32'hDEAD_BEEF, 1'b1);
    push_exp(0, 32'hDEAD_BEEF, 1'b0);
    do_req(0, 1'b1, 10'h05A, 32'h0, 1'b0);

    // Reset so the contention burst starts with r0 winning.
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      a0[i] = 10'(i * 64 + $urandom_range(0, 60));
      a1[i] = 10'(512 + i * 64 + $urandom_range(0, 60));
      d0[i] = $urandom;
      d1[i] = $urandom;
      push_exp(0, 32'h0, 1'b0);
      push_exp(1, 32'h0, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      push_exp(0, d0[i], 1'b0);
      push_exp(1, d1[i], 1'b0);
    end
    gap_en = 1;
    fork
      begin
        for (int i = 0; i < 5; i++) do_req(0, 1'b0, a0[i], d0[i], 1'b0);
        for (int i = 0; i < 5; i++) do_req(0, 1'b1, a0[i], 32'h0, 1'b0);
      end
      begin
        for (int i = 0; i < 5; i++) do_req(1, 1'b0, a1[i], d1[i], 1'b0);
        for (int i = 0; i < 5; i++) do_req(1, 1'b1, a1[i], 32'h0, 1'b0);
      end
    join
    gap_en = 0;

    // Watchdog: memory never ready; r1 times out, then waiting r0 is served.
    lat = 100;
    push_exp(1, 32'h0, 1'b1);
    push_exp(0, 32'h0, 1'b1);
    fork
      do_req(1, 1'b1, 10'h300, 32'h0, 1'b0);
      begin
        repeat (2) @(posedge clk);
        do_req(0, 1'b1, 10'h010, 32'h0, 1'b0);
      end
    join

    // Ready arriving exactly at the deadline is a normal completion.
    lat = 4;
    mem[10'h123] = 32'h1234_5678;
    push_exp(0, 32'h1234_5678, 1'b0);
    do_req(0, 1'b1, 10'h123, 32'h0, 1'b0);
    chk("deadline_cycle", ready_run, TMO);

    // Asynchronous reset while r1 waits on the memory.
    lat = 100;
    push_exp(1, 32'h0, 1'b0);
    fork
      do_req(1, 1'b1, 10'h2AA, 32'h0, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #2;
        chk("pre_reset_req", 32'(mem_req_o), 32'h1);
        reset = 1'b1;
        #1;
        chk("reset_mem_req", 32'(mem_req_o), 32'h0);
        chk("reset_r1_ready", 32'(r1_ready_o), 32'h0);
        @(negedge clk);
        exp0.delete();
        exp1.delete();
        gq.delete();
        @(posedge clk);
        #2 reset = 1'b0;
      end
    join
    #1;
    chk("post_reset_idle", 32'(mem_req_o), 32'h0);
    lat = 1;
    push_exp(0, 32'h0, 1'b0);
    push_exp(1, 32'h0, 1'b0);
    fork
      do_req(0, 1'b0, 10'h011, 32'h0000_0011, 1'b0);
      do_req(1, 1'b0, 10'h211, 32'h0000_0022, 1'b0);
    join

    repeat (3) @(posedge clk);
    chk("exp0_drained", exp0.size(), 0);
    chk("exp1_drained", exp1.size(), 0);
    chk("grants_drained", gq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter that shares the single-port 1024×32 memory between two masters using the memory's req/ready handshake. It sits between two request sources and the memory's request port. It muxes address, write data and read/write select onto the memory and steers ready and read data back to the winner. A per-transaction watchdog terminates hung accesses with an error response so that neither requester can stall indefinitely.

## Interface
Parameters:
- ADDR_W, 10, address width (memory depth 2^ADDR_W words)
- DATA_W, 32, data width
- TIMEOUT, 255, maximum BUSY cycles without mem_ready_i before an error response; must be ≥1; counter width $clog2(TIMEOUT+1)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- r0_req_i  in  1  requester 0 request; held with fields stable until r0_ready_o
- r0_rnw_i  in  1  requester 0: 1 = read, 0 = write
- r0_addr_i  in  ADDR_W  requester 0 word address
- r0_wdata_i  in  DATA_W  requester 0 write data
- r0_ready_o  out  1  requester 0 completion strobe, one cycle
- r0_rdata_o  out  DATA_W  requester 0 read data, valid with r0_ready_o
- r0_err_o  out  1  requester 0 timeout error, valid with r0_ready_o
- r1_req_i, r1_rnw_i, r1_addr_i, r1_wdata_i, r1_ready_o, r1_rdata_o, r1_err_o: same as r0_* for requester 1
- mem_req_o  out  1  memory request
- mem_rnw_o  out  1  memory read/write select
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ready_i  in  1  memory completion
- mem_rdata_i  in  DATA_W  memory read data

## Operation
- State: IDLE or BUSY. Registers: gnt (the granted requester index), last (the index served most recently), and cnt (the watchdog counter).
- IDLE: if exactly one req_i is high, grant that requester. If both are high, grant !last. Then go to BUSY with cnt = 0. If no req_i is high, remain in IDLE.
- BUSY: mem_rnw_o, mem_addr_o and mem_wdata_o are combinational copies of the granted requester's fields.
- mem_req_o = BUSY & granted req_i & !tmo, where tmo = (cnt == TIMEOUT) & !mem_ready_i.
- Completion: if BUSY & mem_req_o & mem_ready_i, then:
  - the granted ready_o = 1 for that cycle;
  - the granted rdata_o = mem_rdata_i;
  - the granted err_o = 0;
  - last ← gnt, and the next state is IDLE.
- Timeout: if BUSY & tmo & granted req_i, then:
  - the granted ready_o = 1, err_o = 1, and rdata_o = 0;
  - mem_req_o = 0;
  - last ← gnt, and the next state is IDLE.
- Otherwise in BUSY, cnt increments each cycle and saturates at TIMEOUT.
- Requester abandons request: if the granted req_i drops while in BUSY, mem_req_o falls the same cycle. The next state is IDLE, no ready_o is issued, and last is unchanged.
- The non-granted requester always sees ready_o = 0, err_o = 0 and rdata_o = 0. Outputs toward a requester are 0 whenever its ready_o is 0.
- The mem_* data fields are don't-care when mem_req_o = 0. The implementation drives them as 0 in IDLE.

## Timing
- Reset values: state = IDLE, gnt = 0, last = 1 (so requester 0 wins the first contention), cnt = 0. All outputs are 0.
- Grant latency: a req_i sampled high in IDLE at edge N gives mem_req_o high in cycle N+1.
- Response path is combinational: mem_ready_i to ready_o and mem_rdata_i to rdata_o in the same cycle.
- Mandatory dead cycle: after a completion or timeout in cycle M, state is IDLE in M+1. The earliest next mem_req_o is in M+2.
- Requester obligation: req_i deasserts in the cycle after its ready_o. A req_i still high in IDLE is treated as a new request.
- Watchdog: the error strobe appears in the (TIMEOUT+1)-th BUSY cycle (cnt == TIMEOUT) if mem_ready_i has stayed low throughout. If mem_ready_i is high in that same cycle, it is a normal completion; normal completion wins.
- Asynchronous reset mid-BUSY: mem_req_o and all ready_o drop immediately with no response. The in-flight access is abandoned.

## Test plan
- Reset, then r0 writes addr 10'h05A with 32'hDEAD_BEEF, memory ready after 1 cycle. Required: mem_req_o high one cycle after r0_req_i, mem_addr_o = 10'h05A, r0_ready_o pulses once, r0_err_o = 0, r1_ready_o never asserts.
- r0 reads addr 10'h05A. Required: r0_rdata_o = 32'hDEAD_BEEF coincident with r0_ready_o.
- r0 and r1 both request continuously with 10 transactions each, using random addresses and data: writes, then readback. Required:
  - grants strictly alternate 0, 1, 0, 1 …, with 0 first after reset;
  - every readback matches the data written to that address by the same requester;
  - there is exactly one IDLE cycle between consecutive mem_req_o pulses.
- TIMEOUT = 4, memory never asserts ready, r1 reads. Required: in the 5th BUSY cycle r1_ready_o = 1, r1_err_o = 1 and r1_rdata_o = 0, with mem_req_o = 0 in that cycle. r0 is granted next if it is requesting.
- TIMEOUT = 4, mem_ready_i rises exactly in the 5th BUSY cycle with mem_rdata_i = 32'h1234_5678. Required: normal completion, err_o = 0, rdata_o = 32'h1234_5678.
- Assert reset asynchronously (mid-cycle) while r1 is granted and waiting. Required:
  - mem_req_o and r1_ready_o are 0 immediately;
  - after release, state is IDLE;
  - simultaneous requests from both requesters grant r0 first.
